conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
Frame-level controller for the 3x3 convolution engine (32x32 image, 22-bit signed results).
- On a host command it pulses the engine start and streams one frame of pixels from a synchronous-read image memory into the engine.
- It writes every engine result into a result memory at consecutive addresses, then reports completion, result count and error status.
- It sits between the host/CSR layer and the engine plus its two memories.

Parameters:
IMG_WIDTH, 32, pixels per line; must match the engine.
IMG_HEIGHT, 32, lines per frame; must match the engine.
PIX_AW, 10, image memory address width; covers IMG_WIDTH*IMG_HEIGHT.
RES_AW, 10, result memory address width.
RES_W, 22, result data width.
DRAIN_TIMEOUT, 64, cycles to wait for engine done after the last pixel.

Ports:
clk  in  1  the single clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
cmd_start  in  1  one-cycle start request; honoured only in IDLE.
cmd_abort  in  1  one-cycle abort request; honoured in any non-IDLE state.
hold  in  1  throttle; while high, no new pixel read is issued.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on normal completion.
err_abort  out  1  sticky; set on abort, cleared by the next accepted cmd_start.
err_timeout  out  1  sticky; set on drain timeout, cleared by the next accepted cmd_start.
res_count  out  RES_AW+1  results written in the current/last frame.
pix_rd_en  out  1  image memory read enable.
pix_addr  out  PIX_AW  image memory read address.
pix_rd_data  in  8  image memory data, valid 1 cycle after pix_rd_en.
eng_start  out  1  to engine start_signal.
eng_pixel  out  8  to engine pixel_in.
eng_pixel_valid  out  1  to engine pixel_valid.
eng_rst  out  1  to engine synchronous active-high reset.
eng_result  in  RES_W  from engine result_out, signed.
eng_result_valid  in  1  from engine result_valid.
eng_done  in  1  from engine done_signal.
res_we  out  1  result memory write enable.
res_addr  out  RES_AW  result memory write address.
res_data  out  RES_W  result memory write data.

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0, counters 0, error flags 0.
  - Exception: eng_rst is 1 while rst is low and for exactly 1 cycle after rst deasserts.
- States: IDLE, KICK, STREAM, DRAIN, FINISH.
- IDLE -> KICK on cmd_start.
  - Clears res_count, both error flags and the read address.
  - cmd_start in any other state is ignored.
- KICK: eng_start=1 for exactly this one cycle, then -> STREAM. The engine is in PROCESSING from the following cycle.
- STREAM, read issue:
  - Each cycle with hold=0 and reads issued < IMG_WIDTH*IMG_HEIGHT: pix_rd_en=1, pix_addr=current read address, then the address increments.
  - With hold=1: pix_rd_en=0 and the address is held.
- STREAM, pixel delivery:
  - eng_pixel_valid is pix_rd_en delayed 1 cycle.
  - eng_pixel = pix_rd_data, registered alongside it.
  - Pixel order is raster: address 0 first, address = y*IMG_WIDTH + x.
- STREAM -> DRAIN in the cycle after the last read's pixel is presented (eng_pixel_valid with count = IMG_WIDTH*IMG_HEIGHT).
- DRAIN:
  - Waits for eng_done, then -> FINISH.
  - If DRAIN_TIMEOUT cycles elapse first: set err_timeout, pulse eng_rst for 1 cycle, -> IDLE, no done.
- FINISH: done=1 for 1 cycle, -> IDLE.
- Result capture, in every state except IDLE:
  - On eng_result_valid, register res_we=1, res_data=eng_result unchanged (no saturation), res_addr=res_count. res_count increments the same cycle.
  - Write latency is 1 cycle.
  - A valid arriving in the same cycle as the last FINISH is still written.
  - res_count saturates at 2^RES_AW; writes beyond that are dropped.
- Expected res_count for a normal frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2) = 900. The block does not check this count; software does.
- Abort, in any non-IDLE state:
  - Next cycle: pix_rd_en=0 and eng_pixel_valid=0; reads in flight are discarded.
  - eng_rst=1 for 1 cycle, err_abort=1, -> IDLE, no done.
  - cmd_abort together with cmd_start in IDLE: start wins.
- hold is ignored outside STREAM.
- eng_start and eng_pixel_valid are never high in the same cycle.
- Asynchronous reset mid-frame: all state is cleared immediately. The engine is restarted through the eng_rst rule above.

Decomposition:
- Shared package conv_pkg: IMG_WIDTH, IMG_HEIGHT, RES_W constants; the sequencer state enum; a result_t typedef (signed RES_W).
- One natural sub-module, conv_pix_fetch: read address counter plus the 1-cycle read-latency alignment (pix_rd_en -> eng_pixel_valid), with a hold input and a flush input for abort.

Test Plan:
- Ramp image (mem[a]=a[7:0]), hold=0, cmd_start -> exactly 1024 reads at addresses 0..1023 on consecutive cycles; exactly 900 writes at addresses 0..899; done 1 pulse; res_count=900; no error flags.
- Same frame with hold high every third cycle -> still 1024 pixels delivered in order with gaps; result memory contents identical to the hold=0 run.
- cmd_start pulsed during STREAM -> ignored; single eng_start pulse; single done.
- cmd_abort after 500 pixels -> eng_rst 1-cycle pulse; err_abort=1; busy=0 next cycle; no done. A following cmd_start clears err_abort, and the frame completes with res_count=900.
- Engine model suppresses eng_done -> DRAIN lasts 64 cycles; err_timeout=1; eng_rst pulse; back in IDLE; done never asserted.
- rst asserted low mid-STREAM -> all outputs 0 immediately; eng_rst=1 during reset and for 1 cycle after. A subsequent frame runs cleanly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution frame sequencer.
package conv_pkg;

  localparam int unsigned IMG_WIDTH  = 32;
  localparam int unsigned IMG_HEIGHT = 32;
  localparam int unsigned RES_W      = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_STREAM,
    ST_DRAIN,
    ST_FINISH
  } seq_state_e;

  typedef logic signed [RES_W-1:0] result_t;

endpackage

// File: rtl/conv_pix_fetch.sv
// Image memory read address generator plus alignment of the 1-cycle
// synchronous read latency onto the engine pixel stream.
module conv_pix_fetch #(
  parameter int unsigned IMG_WIDTH  = conv_pkg::IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = conv_pkg::IMG_HEIGHT,
  parameter int unsigned PIX_AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              hold,
  input  logic              flush,
  output logic              pix_rd_en,
  output logic [PIX_AW-1:0] pix_addr,
  input  logic [7:0]        pix_rd_data,
  output logic              pix_valid,
  output logic [7:0]        pix_data,
  output logic              last_pix
);

  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CW   = PIX_AW + 1;

  logic [CW-1:0] issued;
  logic [CW-1:0] delivered;
  logic          rd_valid_q;

  assign pix_rd_en = enable && !hold && (issued < CW'(NPIX));
  assign pix_addr  = issued[PIX_AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued     <= '0;
      delivered  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (clear) begin
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (pix_rd_en)
          issued <= issued + 1'b1;
        if (rd_valid_q && !flush)
          delivered <= delivered + 1'b1;
      end
      // A flush discards the read issued in the abort cycle.
      rd_valid_q <= pix_rd_en && !flush;
    end
  end

  // The memory's own output register provides the data alignment.
  assign pix_valid = rd_valid_q;
  assign pix_data  = rd_valid_q ? pix_rd_data : '0;
  assign last_pix  = rd_valid_q && (delivered == CW'(NPIX - 1));

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller: kicks the convolution engine, streams one frame
// of pixels into it and stores every result in the result memory.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = conv_pkg::IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT    = conv_pkg::IMG_HEIGHT,
  parameter int unsigned PIX_AW        = 10,
  parameter int unsigned RES_AW        = 10,
  parameter int unsigned RES_W         = conv_pkg::RES_W,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err_abort,
  output logic              err_timeout,
  output logic [RES_AW:0]   res_count,
  output logic              pix_rd_en,
  output logic [PIX_AW-1:0] pix_addr,
  input  logic [7:0]        pix_rd_data,
  output logic              eng_start,
  output logic [7:0]        eng_pixel,
  output logic              eng_pixel_valid,
  output logic              eng_rst,
  input  logic [RES_W-1:0]  eng_result,
  input  logic              eng_result_valid,
  input  logic              eng_done,
  output logic              res_we,
  output logic [RES_AW-1:0] res_addr,
  output logic [RES_W-1:0]  res_data
);

  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

  seq_state_e    state, state_nxt;
  logic [TW-1:0] drain_cnt;
  logic          start_take;
  logic          abort_take;
  logic          timeout_hit;
  logic          fetch_en;
  logic          last_pix;
  logic          capture;
  logic          eng_rst_q;

  conv_pix_fetch #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .PIX_AW    (PIX_AW)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_take),
    .enable     (fetch_en),
    .hold       (hold),
    .flush      (abort_take),
    .pix_rd_en  (pix_rd_en),
    .pix_addr   (pix_addr),
    .pix_rd_data(pix_rd_data),
    .pix_valid  (eng_pixel_valid),
    .pix_data   (eng_pixel),
    .last_pix   (last_pix)
  );

  always_comb begin
    state_nxt   = state;
    start_take  = 1'b0;
    abort_take  = 1'b0;
    timeout_hit = 1'b0;
    busy        = (state != ST_IDLE);
    eng_start   = (state == ST_KICK);
    fetch_en    = (state == ST_STREAM);
    done        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          start_take = 1'b1;
          state_nxt  = ST_KICK;
        end
      end
      ST_KICK:   state_nxt = ST_STREAM;
      ST_STREAM: if (last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (eng_done) begin
          state_nxt = ST_FINISH;
        end else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_FINISH: begin
        done      = !cmd_abort;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort overrides every other transition outside IDLE.
    if (state != ST_IDLE && cmd_abort) begin
      abort_take  = 1'b1;
      timeout_hit = 1'b0;
      state_nxt   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // Held high through reset so the engine restarts cleanly afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      eng_rst_q <= 1'b1;
    else
      eng_rst_q <= abort_take || timeout_hit;
  end

  assign eng_rst = eng_rst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_abort   <= 1'b0;
      err_timeout <= 1'b0;
    end else if (start_take) begin
      err_abort   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (abort_take)
        err_abort <= 1'b1;
      if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end

  // The MSB of res_count marks saturation; further results are dropped.
  assign capture = (state != ST_IDLE) && eng_result_valid && !res_count[RES_AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_count <= '0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end else begin
      res_we <= capture;
      if (start_take) begin
        res_count <= '0;
      end else if (capture) begin
        res_count <= res_count + 1'b1;
        res_addr  <= res_count[RES_AW-1:0];
        res_data  <= eng_result;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer with ramp image memory and a
// behavioural engine model.
module tb_conv_frame_sequencer;

  localparam int unsigned PIX_AW        = 10;
  localparam int unsigned RES_AW        = 10;
  localparam int unsigned RES_W         = 22;
  localparam int unsigned DRAIN_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_abort = 1'b0;
  logic              hold = 1'b0;
  logic              busy, done, err_abort, err_timeout;
  logic [RES_AW:0]   res_count;
  logic              pix_rd_en;
  logic [PIX_AW-1:0] pix_addr;
  logic [7:0]        pix_rd_data = '0;
  logic              eng_start;
  logic [7:0]        eng_pixel;
  logic              eng_pixel_valid;
  logic              eng_rst;
  logic [RES_W-1:0]  eng_result = '0;
  logic              eng_result_valid = 1'b0;
  logic              eng_done = 1'b0;
  logic              res_we;
  logic [RES_AW-1:0] res_addr;
  logic [RES_W-1:0]  res_data;

  conv_frame_sequencer #(
    .IMG_WIDTH    (32),
    .IMG_HEIGHT   (32),
    .PIX_AW       (PIX_AW),
    .RES_AW       (RES_AW),
    .RES_W        (RES_W),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_start       (cmd_start),
    .cmd_abort       (cmd_abort),
    .hold            (hold),
    .busy            (busy),
    .done            (done),
    .err_abort       (err_abort),
    .err_timeout     (err_timeout),
    .res_count       (res_count),
    .pix_rd_en       (pix_rd_en),
    .pix_addr        (pix_addr),
    .pix_rd_data     (pix_rd_data),
    .eng_start       (eng_start),
    .eng_pixel       (eng_pixel),
    .eng_pixel_valid (eng_pixel_valid),
    .eng_rst         (eng_rst),
    .eng_result      (eng_result),
    .eng_result_valid(eng_result_valid),
    .eng_done        (eng_done),
    .res_we          (res_we),
    .res_addr        (res_addr),
    .res_data        (res_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [21:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  bit  hold_mode = 1'b0;
  bit  suppress_done = 1'b0;

  int  reads_frame = 0, pix_frame = 0;
  int  first_rd_cyc = 0, last_rd_cyc = 0;
  int  done_total = 0, start_total = 0;
  int  rst_rises = 0, rst_run = 0, last_rst_len = 0;
  int  last_pix_cyc = 0, rst_rise_cyc = 0;
  logic eng_rst_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ramp image memory with synchronous read.
  always @(posedge clk)
    if (pix_rd_en)
      pix_rd_data <= pix_addr[7:0];

  // Engine model: one result per pixel with x>=2 and y>=2, 1 cycle latency.
  int   eng_idx = 0;
  int   done_dn = 0;
  logic eng_active = 1'b0;
  always @(posedge clk) begin
    eng_result_valid <= 1'b0;
    eng_done         <= 1'b0;
    if (eng_rst || eng_start) begin
      eng_idx    <= 0;
      done_dn    <= 0;
      eng_active <= eng_start && !eng_rst;
    end else begin
      if (eng_pixel_valid && eng_active) begin
        if ((eng_idx % 32) >= 2 && (eng_idx / 32) >= 2) begin
          eng_result_valid <= 1'b1;
          eng_result       <= 22'(-8000 * int'(eng_pixel) + eng_idx);
        end
        eng_idx <= eng_idx + 1;
        if (eng_idx == 1023)
          done_dn <= 6;
      end
      if (done_dn > 0) begin
        done_dn <= done_dn - 1;
        if (done_dn == 1) begin
          eng_done   <= !suppress_done;
          eng_active <= 1'b0;
        end
      end
    end
  end

  int hcnt = 0;
  always @(posedge clk) begin
    #2;
    hcnt++;
    hold = hold_mode && (hcnt % 3 == 0);
  end

  // Monitor: pops the scoreboard on every result write and tracks streams.
  always @(negedge clk) begin
    cyc++;
    if (eng_start) begin
      reads_frame = 0;
      pix_frame   = 0;
      start_total++;
      chk("start_vs_valid", eng_pixel_valid, 0);
    end
    if (pix_rd_en) begin
      chk("rd_addr", pix_addr, reads_frame);
      if (reads_frame == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      reads_frame++;
    end
    if (eng_pixel_valid) begin
      chk("pix_order", eng_pixel, pix_frame % 256);
      pix_frame++;
      if (pix_frame == 1024) last_pix_cyc = cyc;
    end
    if (done) done_total++;
    if (eng_rst && !eng_rst_prev) begin
      rst_rises++;
      rst_rise_cyc = cyc;
    end
    if (eng_rst) rst_run++;
    else if (rst_run > 0) begin
      last_rst_len = rst_run;
      rst_run = 0;
    end
    eng_rst_prev = eng_rst;
    if (res_we) begin
      chk("write_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("res_addr", res_addr, e.addr);
        chk("res_data", res_data, e.data);
      end
    end
  end

  task automatic push_expected();
    for (int k = 0; k < 900; k++) begin
      wr_t e;
      int  p;
      p      = (k / 30 + 2) * 32 + (k % 30 + 2);
      e.addr = k;
      e.data = 22'(-8000 * (p % 256) + p);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic run_frame(input string tag, input int restart_at);
    int d0, s0;
    d0 = done_total;
    s0 = start_total;
    push_expected();
    pulse_start();
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_err_abort_clr"}, err_abort, 0);
    chk({tag, "_err_timeout_clr"}, err_timeout, 0);
    if (restart_at > 0) begin
      repeat (restart_at) @(posedge clk);
      #1;
      pulse_start();
    end
    wait_idle(4000, tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_reads"}, reads_frame, 1024);
    chk({tag, "_pixels"}, pix_frame, 1024);
    chk({tag, "_res_count"}, res_count, 900);
    chk({tag, "_done_pulses"}, done_total - d0, 1);
    chk({tag, "_start_pulses"}, start_total - s0, 1);
    chk({tag, "_err_abort"}, err_abort, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, r0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_err_abort", err_abort, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_pix_rd_en", pix_rd_en, 0);
    chk("rst_res_we", res_we, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("eng_rst_after_release", eng_rst, 1);
    @(posedge clk); #1;
    chk("eng_rst_cleared", eng_rst, 0);

    // Plain frame, back-to-back reads.
    run_frame("frame", 0);
    chk("frame_consecutive_reads", last_rd_cyc - first_rd_cyc, 1023);

    // Throttled frame.
    hold_mode = 1'b1;
    run_frame("hold", 0);
    hold_mode = 1'b0;
    chk("hold_gaps_present", (last_rd_cyc - first_rd_cyc) > 1023, 1);

    // Start during STREAM is ignored.
    run_frame("restart", 100);

    // Abort after 500 pixels.
    d0 = done_total;
    r0 = rst_rises;
    push_expected();
    pulse_start();
    n = 0;
    while (pix_frame < 500 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_500", pix_frame >= 500, 1);
    cmd_abort = 1'b1;
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_eng_rst", eng_rst, 1);
    chk("abort_err", err_abort, 1);
    chk("abort_rd_en", pix_rd_en, 0);
    chk("abort_pix_valid", eng_pixel_valid, 0);
    @(posedge clk); #1;
    chk("abort_eng_rst_end", eng_rst, 0);
    chk("abort_err_sticky", err_abort, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_total - d0, 0);
    chk("abort_rst_pulses", rst_rises - r0, 1);
    chk("abort_rst_len", last_rst_len, 1);
    exp_q.delete();
    run_frame("after_abort", 0);

    // Drain timeout.
    suppress_done = 1'b1;
    d0 = done_total;
    r0 = rst_rises;
    push_expected();
    pulse_start();
    wait_idle(4000, "timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_no_done", done_total - d0, 0);
    chk("timeout_rst_pulses", rst_rises - r0, 1);
    chk("timeout_rst_len", last_rst_len, 1);
    chk("timeout_drain_len", rst_rise_cyc - last_pix_cyc, DRAIN_TIMEOUT + 1);
    chk("timeout_res_count", res_count, 900);
    chk("timeout_writes_left", exp_q.size(), 0);
    suppress_done = 1'b0;

    // Asynchronous reset mid-STREAM.
    push_expected();
    pulse_start();
    repeat (200) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", pix_rd_en, 0);
    chk("arst_pix_addr", pix_addr, 0);
    chk("arst_pix_valid", eng_pixel_valid, 0);
    chk("arst_pixel", eng_pixel, 0);
    chk("arst_res_we", res_we, 0);
    chk("arst_res_count", res_count, 0);
    chk("arst_err_timeout", err_timeout, 0);
    chk("arst_eng_rst", eng_rst, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("arst_eng_rst_after", eng_rst, 1);
    @(posedge clk); #1;
    chk("arst_eng_rst_end", eng_rst, 0);
    chk("arst_idle", busy, 0);
    exp_q.delete();
    run_frame("post_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule
